// File: rtl/depp_host_master.sv
// depp_host_master
//   Host-side Digilent EPP initiator. Each accepted single-byte command
//   (address write/read, data write/read) becomes one EPP bus cycle on
//   astb_n/dstb_n/write_n/data, paced by the peripheral's wait handshake.
//   Every command produces exactly one response pulse, carrying either the
//   read byte or a timeout error.
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake (ready only in IDLE)
//   i_cmd_type[1:0]         00 addr wr, 01 data wr, 10 data rd, 11 addr rd
//   i_cmd_data[7:0]         write byte
//   o_rsp_valid             one-cycle response pulse
//   o_rsp_data[7:0]         read byte (0 for writes and timeouts)
//   o_rsp_err               response is a timeout abort
//   o_astb_n, o_dstb_n      EPP address / data strobes (active low)
//   o_write_n               EPP direction, 0 = host writes
//   o_depp, o_depp_oe       host data and pad output enable
//   i_depp                  peripheral read data
//   i_wait                  peripheral wait, asynchronous
module depp_host_master #(
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 1023,
  parameter int TW           = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_type,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic       o_astb_n,
  output logic       o_dstb_n,
  output logic       o_write_n,
  output logic [7:0] o_depp,
  output logic       o_depp_oe,
  input  logic [7:0] i_depp,
  input  logic       i_wait
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_type, w_type_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;

  logic       r_astb_n, w_astb_n_nxt;
  logic       r_dstb_n, w_dstb_n_nxt;
  logic       r_write_n, w_write_n_nxt;
  logic [7:0] r_depp, w_depp_nxt;
  logic       r_depp_oe, w_depp_oe_nxt;
  logic       r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0] r_rsp_data, w_rsp_data_nxt;
  logic       r_rsp_err, w_rsp_err_nxt;

  logic w_wait_s, w_accept, w_timeout, w_setup_done, w_is_addr, w_is_read;

  assign w_wait_s     = r_sync[1];
  assign w_accept     = i_cmd_valid && (r_state == S_IDLE);
  assign w_timeout    = (r_state != S_IDLE) && (r_cnt == TW'(TIMEOUT));
  // r_cnt is cleared on accept, so it doubles as the setup-time counter
  assign w_setup_done = (r_cnt >= TW'(SETUP_CYCLES - 1));
  // types 00 and 11 address the peripheral's address register
  assign w_is_addr    = (r_type[1] == r_type[0]);
  assign w_is_read    = r_type[1];

  // wait is fully asynchronous to us
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_wait};
  end

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept)                   w_state_nxt = S_SETUP;
      // a still-high wait means the peripheral has not finished a prior cycle
      S_SETUP:  if (w_setup_done && !w_wait_s)  w_state_nxt = S_STROBE;
      S_STROBE: if (w_wait_s)                   w_state_nxt = S_HOLD;
      S_HOLD:   if (!w_wait_s)                  w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  // ---- FSM: registered-output next values ----
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_type_nxt      = r_type;
    w_rdata_nxt     = r_rdata;
    w_astb_n_nxt    = r_astb_n;
    w_dstb_n_nxt    = r_dstb_n;
    w_write_n_nxt   = r_write_n;
    w_depp_nxt      = r_depp;
    w_depp_oe_nxt   = r_depp_oe;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;

    if (r_state != S_IDLE) w_cnt_nxt = r_cnt + TW'(1);

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt     = '0;
          w_type_nxt    = i_cmd_type;
          w_write_n_nxt = i_cmd_type[1];
          w_depp_nxt    = i_cmd_type[1] ? 8'h00 : i_cmd_data;
          w_depp_oe_nxt = !i_cmd_type[1];
        end
      end
      S_SETUP: begin
        if (w_setup_done && !w_wait_s) begin
          w_astb_n_nxt = !w_is_addr;
          w_dstb_n_nxt = w_is_addr;
        end
      end
      S_STROBE: begin
        if (w_wait_s) begin
          // peripheral holds i_depp stable while wait is high
          w_rdata_nxt  = w_is_read ? i_depp : 8'h00;
          w_astb_n_nxt = 1'b1;
          w_dstb_n_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (!w_wait_s) begin
          w_depp_oe_nxt   = 1'b0;
          w_write_n_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = r_rdata;
          w_rsp_err_nxt   = 1'b0;
        end
      end
      default: ;
    endcase

    if (w_timeout) begin
      w_astb_n_nxt    = 1'b1;
      w_dstb_n_nxt    = 1'b1;
      w_depp_oe_nxt   = 1'b0;
      w_write_n_nxt   = 1'b1;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_data_nxt  = 8'h00;
      w_rsp_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_type      <= 2'b00;
      r_rdata     <= 8'h00;
      r_astb_n    <= 1'b1;
      r_dstb_n    <= 1'b1;
      r_write_n   <= 1'b1;
      r_depp      <= 8'h00;
      r_depp_oe   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_type      <= w_type_nxt;
      r_rdata     <= w_rdata_nxt;
      r_astb_n    <= w_astb_n_nxt;
      r_dstb_n    <= w_dstb_n_nxt;
      r_write_n   <= w_write_n_nxt;
      r_depp      <= w_depp_nxt;
      r_depp_oe   <= w_depp_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_astb_n    = r_astb_n;
  assign o_dstb_n    = r_dstb_n;
  assign o_write_n   = r_write_n;
  assign o_depp      = r_depp;
  assign o_depp_oe   = r_depp_oe;

endmodule

// File: tb/tb_depp_host_master.sv
// Directed bench for depp_host_master with a small EPP peripheral model.
// Runs with SETUP_CYCLES=2, TIMEOUT=20.
module tb_depp_host_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       rdy;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       astb_n, dstb_n, write_n, oe;
  logic [7:0] depp;
  logic [7:0] depp_in = 8'h00;
  logic       wait_in = 1'b0;

  // peripheral model control
  logic per_auto = 1'b0;
  logic per_man  = 1'b0;
  int   lo_n = 0;
  int   hi_n = 0;

  int errs = 0;
  int checks = 0;

  depp_host_master #(.SETUP_CYCLES(2), .TIMEOUT(20), .TW(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy),
    .i_cmd_type(cmd_type), .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_astb_n(astb_n), .o_dstb_n(dstb_n), .o_write_n(write_n),
    .o_depp(depp), .o_depp_oe(oe), .i_depp(depp_in), .i_wait(wait_in)
  );

  always #5 clk = ~clk;

  // Auto mode: raise wait 2 cycles after a strobe falls, drop it 2 cycles
  // after the strobe rises. Manual mode: wait follows per_man.
  always @(posedge clk) begin
    #2;
    if (per_auto) begin
      if (!astb_n || !dstb_n) begin
        hi_n = 0; lo_n++;
        if (lo_n >= 2) wait_in = 1'b1;
      end else begin
        lo_n = 0;
        if (wait_in) begin
          hi_n++;
          if (hi_n >= 2) wait_in = 1'b0;
        end else hi_n = 0;
      end
    end else begin
      lo_n = 0; hi_n = 0;
      wait_in = per_man;
    end
  end

  // Present a command and return #1 after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd_type = t; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rdy !== 1'b1) begin errs++; $display("FAIL send_accept: ready=%b required 1", rdy); end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({astb_n, dstb_n, write_n, oe, depp} !== {4'b1110, 8'h00}) begin
      errs++; $display("FAIL reset_pins: astb,dstb,wr,oe,depp=%b%b%b%b %h required 1110 00", astb_n, dstb_n, write_n, oe, depp);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 10'h000) begin
      errs++; $display("FAIL reset_rsp: valid=%b err=%b data=%h required 0 0 00", rsp_valid, rsp_err, rsp_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b required 1", rdy); end
  endtask

  task automatic test_addr_write();
    int viol, pulses; logic got, a1, a2, er; logic [7:0] rd;
    viol = 0; pulses = 0; got = 0; a1 = 0; a2 = 1; er = 1'bx; rd = 8'hxx;
    per_auto = 1'b1;
    send(2'b00, 8'h5A);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) a1 = astb_n;
      if (n == 2) a2 = astb_n;
      if (dstb_n !== 1'b1) viol++;
      if (!rsp_valid) begin
        if (depp !== 8'h5A || oe !== 1'b1 || write_n !== 1'b0) viol++;
      end else begin
        got = 1; pulses++; rd = rsp_data; er = rsp_err;
      end
    end
    checks++; if (a1 !== 1'b1) begin errs++; $display("FAIL aw_astb_early: got %b required 1", a1); end
    checks++; if (a2 !== 1'b0) begin errs++; $display("FAIL aw_astb_fall: got %b required 0", a2); end
    checks++; if (viol !== 0) begin errs++; $display("FAIL aw_bus_hold: %0d bad cycles required 0", viol); end
    checks++; if (got !== 1'b1) begin errs++; $display("FAIL aw_rsp_seen: got %b required 1", got); end
    checks++; if ({er, rd} !== 9'h000) begin errs++; $display("FAIL aw_rsp: err=%b data=%h required 0 00", er, rd); end
    repeat (3) begin @(negedge clk); if (rsp_valid) pulses++; end
    checks++; if (pulses !== 1) begin errs++; $display("FAIL aw_pulses: got %0d required 1", pulses); end
    checks++; if (rdy !== 1'b1) begin errs++; $display("FAIL aw_ready_after: got %b required 1", rdy); end
  endtask

  task automatic test_data_read();
    int viol; logic got, saw_d, er; logic [7:0] rd;
    viol = 0; got = 0; saw_d = 0; er = 1'bx; rd = 8'hxx;
    per_auto = 1'b1; depp_in = 8'hC3;
    send(2'b10, 8'h00);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (write_n !== 1'b1 || oe !== 1'b0 || astb_n !== 1'b1) viol++;
      if (!dstb_n) saw_d = 1;
      if (rsp_valid) begin got = 1; rd = rsp_data; er = rsp_err; end
      else if (rdy !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin errs++; $display("FAIL dr_bus: %0d bad cycles required 0", viol); end
    checks++; if (saw_d !== 1'b1) begin errs++; $display("FAIL dr_dstb_used: got %b required 1", saw_d); end
    checks++; if ({got, er, rd} !== {2'b10, 8'hC3}) begin
      errs++; $display("FAIL dr_rsp: seen=%b err=%b data=%h required 1 0 c3", got, er, rd);
    end
    @(negedge clk);
    checks++; if ({rdy, rsp_valid, rsp_data} !== {2'b10, 8'hC3}) begin
      errs++; $display("FAIL dr_after: ready=%b valid=%b data=%h required 1 0 c3", rdy, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ty [3]; logic [7:0] dt [3];
    logic [1:0] f_kind [3]; logic [7:0] f_depp [3]; logic f_oe [3];
    logic [7:0] r_data [3]; logic r_err [3];
    int idx, nf, nr, ovl; logic pend, pa, pd;
    ty[0] = 2'b00; dt[0] = 8'h01;
    ty[1] = 2'b01; dt[1] = 8'hFF;
    ty[2] = 2'b10; dt[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      f_kind[i] = 2'b00; f_depp[i] = 8'h00; f_oe[i] = 1'b0; r_data[i] = 8'hxx; r_err[i] = 1'bx;
    end
    idx = 0; nf = 0; nr = 0; ovl = 0; pend = 0;
    per_auto = 1'b1; depp_in = 8'h7E;
    @(negedge clk);
    pa = astb_n; pd = dstb_n;
    cmd_type = ty[0]; cmd_data = dt[0]; cmd_valid = 1'b1;
    for (int c = 0; c < 200 && nr < 3; c++) begin
      if (cmd_valid && rdy) pend = 1;
      @(negedge clk);
      if (pend) begin
        pend = 0; idx++;
        if (idx < 3) begin cmd_type = ty[idx]; cmd_data = dt[idx]; end
        else cmd_valid = 1'b0;
      end
      if (!astb_n && !dstb_n) ovl++;
      if (nf < 3 && ((pa && !astb_n) || (pd && !dstb_n))) begin
        f_kind[nf] = {!astb_n, !dstb_n}; f_depp[nf] = depp; f_oe[nf] = oe; nf++;
      end
      if (rsp_valid) begin r_data[nr] = rsp_data; r_err[nr] = rsp_err; nr++; end
      pa = astb_n; pd = dstb_n;
    end
    cmd_valid = 1'b0;
    checks++; if (ovl !== 0) begin errs++; $display("FAIL b2b_overlap: %0d cycles required 0", ovl); end
    checks++; if (nr !== 3) begin errs++; $display("FAIL b2b_rsp_count: got %0d required 3", nr); end
    checks++; if ({f_kind[0], f_depp[0], f_oe[0]} !== {2'b10, 8'h01, 1'b1}) begin
      errs++; $display("FAIL b2b_txn0: strobe=%b depp=%h oe=%b required 10 01 1", f_kind[0], f_depp[0], f_oe[0]);
    end
    checks++; if ({f_kind[1], f_depp[1], f_oe[1]} !== {2'b01, 8'hFF, 1'b1}) begin
      errs++; $display("FAIL b2b_txn1: strobe=%b depp=%h oe=%b required 01 ff 1", f_kind[1], f_depp[1], f_oe[1]);
    end
    checks++; if ({f_kind[2], f_oe[2]} !== {2'b01, 1'b0}) begin
      errs++; $display("FAIL b2b_txn2: strobe=%b oe=%b required 01 0", f_kind[2], f_oe[2]);
    end
    checks++; if ({r_err[0], r_data[0], r_err[1], r_data[1], r_err[2], r_data[2]} !== {9'h000, 9'h000, 1'b0, 8'h7E}) begin
      errs++; $display("FAIL b2b_rsp_data: %b/%h %b/%h %b/%h required 0/00 0/00 0/7e",
                       r_err[0], r_data[0], r_err[1], r_data[1], r_err[2], r_data[2]);
    end
  endtask

  task automatic test_timeout();
    int viol; logic [13:0] at21;
    viol = 0; at21 = '0;
    per_auto = 1'b0; per_man = 1'b0;
    repeat (3) @(negedge clk);
    send(2'b01, 8'h11);
    for (int n = 0; n <= 21; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= 20 && dstb_n !== 1'b0) viol++;
      if (n <= 20 && rsp_valid !== 1'b0) viol++;
      if (n == 21) at21 = {astb_n, dstb_n, oe, write_n, rsp_valid, rsp_err, rsp_data};
    end
    checks++; if (viol !== 0) begin errs++; $display("FAIL to_before: %0d bad cycles required 0", viol); end
    checks++; if (at21 !== {6'b110111, 8'h00}) begin
      errs++; $display("FAIL to_abort: astb,dstb,oe,wr,valid,err,data=%b required 11011100000000", at21);
    end
    @(negedge clk);
    checks++; if ({rdy, rsp_valid} !== 2'b10) begin
      errs++; $display("FAIL to_ready_next: ready=%b valid=%b required 1 0", rdy, rsp_valid);
    end
  endtask

  task automatic test_wait_stuck();
    int viol, n; logic a10, got, er; logic [7:0] rd;
    viol = 0; a10 = 1; got = 0; er = 1'bx; rd = 8'hxx;
    per_auto = 1'b0; per_man = 1'b1; depp_in = 8'h96;
    repeat (4) @(negedge clk);
    send(2'b11, 8'h00);
    for (n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n <= 9 && astb_n !== 1'b1) viol++;
      if (n == 6) per_man = 1'b0;
      if (n == 10) a10 = astb_n;
    end
    checks++; if (viol !== 0) begin errs++; $display("FAIL ws_early_strobe: %0d cycles required 0", viol); end
    checks++; if (a10 !== 1'b0) begin errs++; $display("FAIL ws_strobe_fall: astb_n=%b required 0", a10); end
    per_man = 1'b1;
    n = 0;
    while (!astb_n == 1'b1 && n < 20) begin @(negedge clk); n++; end
    per_man = 1'b0;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; rd = rsp_data; er = rsp_err; end
    end
    checks++; if ({got, er, rd} !== {2'b10, 8'h96}) begin
      errs++; $display("FAIL ws_rsp: seen=%b err=%b data=%h required 1 0 96", got, er, rd);
    end
  endtask

  task automatic test_reset_mid();
    int viol, n; logic got, er; logic [7:0] rd;
    viol = 0; got = 0; er = 1'bx; rd = 8'hxx;
    per_auto = 1'b0; per_man = 1'b0;
    repeat (3) @(negedge clk);
    send(2'b01, 8'hA5);
    n = 0;
    while (dstb_n && n < 10) begin @(negedge clk); n++; end
    checks++; if ({dstb_n, oe} !== 2'b01) begin
      errs++; $display("FAIL rm_in_strobe: dstb_n=%b oe=%b required 0 1", dstb_n, oe);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({dstb_n, astb_n, oe, write_n, depp, rsp_valid} !== {4'b1101, 8'h00, 1'b0}) begin
      errs++; $display("FAIL rm_immediate: dstb,astb,oe,wr=%b%b%b%b depp=%h valid=%b required 1101 00 0",
                       dstb_n, astb_n, oe, write_n, depp, rsp_valid);
    end
    repeat (2) begin @(negedge clk); if (rsp_valid) viol++; end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) viol++;
    checks++; if (viol !== 0) begin errs++; $display("FAIL rm_no_rsp: %0d pulses required 0", viol); end
    checks++; if (rdy !== 1'b1) begin errs++; $display("FAIL rm_ready: got %b required 1", rdy); end
    per_auto = 1'b1; depp_in = 8'h5D;
    send(2'b10, 8'h00);
    for (n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; rd = rsp_data; er = rsp_err; end
    end
    checks++; if ({got, er, rd} !== {2'b10, 8'h5D}) begin
      errs++; $display("FAIL rm_next_cmd: seen=%b err=%b data=%h required 1 0 5d", got, er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_read();
    test_back_to_back();
    test_timeout();
    test_wait_stuck();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/depp_host_master.md
Name: depp_host_master

Overview:
- DEPP host-side initiator: turns single-byte commands (address write/read, data write/read) into Digilent EPP bus cycles on astb_n/dstb_n/write_n/data, with wait handshake.
- It is the opposite end of the DEPP-to-Wishbone bridge peripheral.
- Sits between an on-chip command source (Raspberry Pi GPIO front end, test sequencer) and the DEPP pins driving the bridge.
- One transaction outstanding at a time; each command returns one response, carrying read data or a timeout error.

Parameters:
- SETUP_CYCLES, 2: cycles write_n/data are driven before the strobe falls; minimum 1.
- TIMEOUT, 1023: max cycles spent outside IDLE before abort; must exceed SETUP_CYCLES+4.
- TW, 10: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  high only in IDLE; command accepted when valid&ready
- i_cmd_type  in  2  00 addr write, 01 data write, 10 data read, 11 addr read
- i_cmd_data  in  8  byte to write (ignored for reads)
- o_rsp_valid  out  1  one-cycle pulse at transaction end
- o_rsp_data  out  8  captured read byte; 0 for writes/timeouts
- o_rsp_err  out  1  qualifies o_rsp_valid: 1 = timeout abort
- o_astb_n  out  1  address strobe, active low
- o_dstb_n  out  1  data strobe, active low
- o_write_n  out  1  0 = host writes
- o_depp  out  8  host drive data
- o_depp_oe  out  1  pad output enable for o_depp
- i_depp  in  8  peripheral read data
- i_wait  in  1  peripheral wait/ack (asynchronous)

Behaviour:
- Reset (async, immediate):
  - o_astb_n=o_dstb_n=o_write_n=1; o_depp=0; o_depp_oe=0.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
  - state=IDLE, so o_cmd_ready=1 after reset releases. Sync flops clear to 0.
  - Reset mid-transaction drops the strobe and tristates in the same instant; no response is issued.
- i_wait passes through a 2-flop synchronizer (wait_s). i_depp is sampled directly; the peripheral holds it stable while wait is high.
- Outputs are registered; o_cmd_ready = (state==IDLE).
- FSM:
  - IDLE: on valid&ready, latch type/data. o_write_n = type[1]; for writes, o_depp=data and o_depp_oe=1. Clear the counter, go to SETUP.
  - SETUP: stay SETUP_CYCLES cycles. If wait_s=1 at the end, stay until wait_s=0 (peripheral still busy from a prior cycle). Then assert the strobe: astb_n for types 00/11, dstb_n for 01/10. Go to STROBE.
  - STROBE: strobe held low until wait_s=1. On that cycle: capture i_depp into o_rsp_data for reads, raise the strobe, go to HOLD.
  - HOLD: strobe high, write data/oe still held. When wait_s=0: o_depp_oe=0, o_write_n=1, pulse o_rsp_valid (err=0), go to IDLE.
- Timeout:
  - The counter increments every non-IDLE cycle.
  - When it equals TIMEOUT, in any non-IDLE state and overriding the normal transition: both strobes=1, oe=0, write_n=1, o_rsp_data=0, o_rsp_valid=1 with o_rsp_err=1, go to IDLE.
- Latency (no peripheral delay, wait responds in 1 cycle): accept → strobe low = 1+SETUP_CYCLES cycles. Total ≈ SETUP_CYCLES + 2×(1+2 sync) + 1.
- New command can be accepted the cycle after o_rsp_valid. A command offered while busy waits; valid must be held until ready.
- o_rsp_data holds its value until the next response. Writes drive o_rsp_data=0.
- Only one strobe is ever low; both are never low together.
- When o_depp_oe=1, o_write_n=0.

Test Plan:
- Address write 0x5A, peripheral asserts wait 2 cycles after astb_n falls and releases 2 cycles after it rises:
  - astb_n low exactly 1+SETUP_CYCLES cycles after accept; o_depp=0x5A, oe=1, write_n=0 throughout.
  - dstb_n stays 1; one rsp_valid with err=0, data=0x00.
- Data read, peripheral drives 0xC3 with wait:
  - dstb_n used, write_n=1, oe=0 whole cycle.
  - rsp_valid with data=0xC3, err=0; o_cmd_ready low from accept until the cycle after the response.
- Back-to-back: addr write 0x01, data write 0xFF, data read (returns 0x7E), valid held continuously:
  - Three transactions in order, three rsp pulses, last data=0x7E, no strobe overlap.
- Peripheral never asserts wait (TIMEOUT=20):
  - strobe released and rsp_valid=1, err=1, data=0 exactly when the counter reaches 20; ready=1 on the next cycle.
- Wait stuck high at accept, released after 10 cycles:
  - Strobe does not fall until 2 cycles (sync) after wait drops.
- Async reset asserted while dstb_n is low in STROBE:
  - dstb_n=1 and oe=0 immediately, no rsp_valid.
  - After release, ready=1 and the next command completes normally.
